// File: rtl/multi_operand_entry.sv
// Button-driven decimal entry of OPERANDS operands, each converted to a NUM_W-bit
// binary value (two's complement when ALLOW_NEG=1); done rises after the last one.
module multi_operand_entry #(
  parameter int NUM_W     = 18,
  parameter int DIGITS    = 5,
  parameter int OPERANDS  = 2,
  parameter int ALLOW_NEG = 0
) (
  input  logic                                              freq625m,
  input  logic                                              rst,
  input  logic                                              btnC,
  input  logic                                              btnU,
  input  logic                                              btnD,
  input  logic                                              btnL,
  input  logic                                              btnR,
  output logic [OPERANDS*NUM_W-1:0]                         nums,
  output logic                                              done,
  output logic                                              busy,
  output logic [((OPERANDS > 1) ? $clog2(OPERANDS) : 1)-1:0] op_idx,
  output logic [$clog2(DIGITS+1)-1:0]                       cursor,
  output logic [4*DIGITS-1:0]                               digits_bcd,
  output logic                                              neg,
  output logic [OPERANDS-1:0]                               ovf
);

  localparam int OP_W   = (OPERANDS > 1) ? $clog2(OPERANDS) : 1;
  localparam int CUR_W  = $clog2(DIGITS + 1);
  localparam int STEP_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ACC_W  = NUM_W + 4;

  localparam logic [ACC_W-1:0]  LIMIT    = (ALLOW_NEG != 0) ? {5'd0, {(NUM_W-1){1'b1}}}
                                                            : {4'd0, {NUM_W{1'b1}}};
  localparam logic [CUR_W-1:0]  CUR_SIGN = CUR_W'(DIGITS);
  localparam logic [CUR_W-1:0]  CUR_MAX  = (ALLOW_NEG != 0) ? CUR_W'(DIGITS) : CUR_W'(DIGITS - 1);
  localparam logic [CUR_W-1:0]  CUR_ONE  = CUR_W'(1);
  localparam logic [OP_W-1:0]   OP_LAST  = OP_W'(OPERANDS - 1);
  localparam logic [OP_W-1:0]   OP_ONE   = OP_W'(1);
  localparam logic [STEP_W-1:0] STEP_TOP = STEP_W'(DIGITS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [NUM_W-1:0]  NUM_ONE  = NUM_W'(1);

  // state | meaning
  // ENTRY | digits editable, cursor/sign moves, C starts conversion
  // CONV  | one digit folded into acc per cycle, MSD first; buttons ignored
  // DONE  | all operands valid and held; only C (restart) is honoured
  typedef enum logic [1:0] {ENTRY = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [4:0] btn, prev, edges;
  logic       act_c, act_u, act_d, act_l, act_r;

  logic [3:0]                dig     [DIGITS];
  logic [3:0]                dig_nxt [DIGITS];
  logic [CUR_W-1:0]          cursor_nxt;
  logic                      neg_nxt;
  logic [OP_W-1:0]           op_idx_nxt;
  logic [OPERANDS*NUM_W-1:0] nums_nxt;
  logic [OPERANDS-1:0]       ovf_nxt;
  logic                      done_nxt;
  logic [ACC_W-1:0]          acc, acc_nxt, acc_step;
  logic                      sticky, sticky_nxt, step_ovf;
  logic [STEP_W-1:0]         step, step_nxt;
  logic [3:0]                dig_sel;
  logic [NUM_W-1:0]          mag, result;

  assign btn   = {btnC, btnU, btnD, btnL, btnR};
  assign edges = btn & ~prev;
  assign act_c = edges[4];
  assign act_u = edges[3] & ~edges[4];
  assign act_d = edges[2] & ~(|edges[4:3]);
  assign act_l = edges[1] & ~(|edges[4:2]);
  assign act_r = edges[0] & ~(|edges[4:1]);

  assign busy = (state == CONV);

  always_comb begin
    digits_bcd = '0;
    for (int i = 0; i < DIGITS; i++) digits_bcd[4*i +: 4] = dig[i];
  end

  always_comb begin
    dig_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (step == STEP_W'(i)) dig_sel = dig[i];
  end

  // acc never exceeds LIMIT between steps, so acc*10+9 always fits in ACC_W bits
  assign acc_step = (acc << 3) + (acc << 1) + {{NUM_W{1'b0}}, dig_sel};
  assign step_ovf = (acc_step > LIMIT);
  assign mag      = step_ovf ? LIMIT[NUM_W-1:0] : acc_step[NUM_W-1:0];
  assign result   = neg ? (~mag + NUM_ONE) : mag;

  always_comb begin
    state_nxt  = state;
    dig_nxt    = dig;
    cursor_nxt = cursor;
    neg_nxt    = neg;
    op_idx_nxt = op_idx;
    nums_nxt   = nums;
    ovf_nxt    = ovf;
    done_nxt   = done;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    step_nxt   = step;
    case (state)
      ENTRY: begin
        if (act_c) begin
          state_nxt  = CONV;
          acc_nxt    = '0;
          sticky_nxt = 1'b0;
          step_nxt   = STEP_TOP;
        end else if (act_u || act_d) begin
          if ((ALLOW_NEG != 0) && (cursor == CUR_SIGN)) begin
            neg_nxt = ~neg;
          end else begin
            for (int i = 0; i < DIGITS; i++) begin
              if (cursor == CUR_W'(i)) begin
                if (act_u) dig_nxt[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
                else       dig_nxt[i] = (dig[i] == 4'd0) ? 4'd9 : dig[i] - 4'd1;
              end
            end
          end
        end else if (act_l) begin
          if (cursor != CUR_MAX) cursor_nxt = cursor + CUR_ONE;
        end else if (act_r) begin
          if (cursor != '0) cursor_nxt = cursor - CUR_ONE;
        end
      end
      CONV: begin
        acc_nxt    = {4'd0, mag};
        sticky_nxt = sticky | step_ovf;
        if (step == '0) begin
          for (int k = 0; k < OPERANDS; k++) begin
            if (op_idx == OP_W'(k)) begin
              nums_nxt[k*NUM_W +: NUM_W] = result;
              ovf_nxt[k]                 = sticky | step_ovf;
            end
          end
          for (int i = 0; i < DIGITS; i++) dig_nxt[i] = 4'd0;
          cursor_nxt = '0;
          neg_nxt    = 1'b0;
          if (op_idx == OP_LAST) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            op_idx_nxt = op_idx + OP_ONE;
            state_nxt  = ENTRY;
          end
        end else begin
          step_nxt = step - STEP_ONE;
        end
      end
      DONE: begin
        if (act_c) begin
          nums_nxt   = '0;
          ovf_nxt    = '0;
          op_idx_nxt = '0;
          done_nxt   = 1'b0;
          state_nxt  = ENTRY;
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  always_ff @(posedge freq625m) begin
    if (rst) state <= ENTRY;
    else     state <= state_nxt;
  end

  always_ff @(posedge freq625m) begin
    if (rst) begin
      prev   <= '0;
      for (int i = 0; i < DIGITS; i++) dig[i] <= 4'd0;
      cursor <= '0;
      neg    <= 1'b0;
      op_idx <= '0;
      nums   <= '0;
      ovf    <= '0;
      done   <= 1'b0;
      acc    <= '0;
      sticky <= 1'b0;
      step   <= '0;
    end else begin
      prev   <= btn;
      dig    <= dig_nxt;
      cursor <= cursor_nxt;
      neg    <= neg_nxt;
      op_idx <= op_idx_nxt;
      nums   <= nums_nxt;
      ovf    <= ovf_nxt;
      done   <= done_nxt;
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
      step   <= step_nxt;
    end
  end

endmodule

// File: tb/tb_multi_operand_entry.sv
// Bench for multi_operand_entry: three configurations (default, signed, 6-digit)
// driven by directed scenarios plus random button sequences against a decimal model.
module tb_multi_operand_entry;

  logic       freq625m = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn [3];   // {C,U,D,L,R} per instance
  int checks = 0;
  int failures = 0;

  always #5 freq625m = ~freq625m;

  logic [35:0] nums0, nums1, nums2;
  logic        done0, done1, done2, busy0, busy1, busy2, neg0, neg1, neg2;
  logic [0:0]  op0, op1, op2;
  logic [2:0]  cur0, cur1, cur2;
  logic [19:0] bcd0, bcd1;
  logic [23:0] bcd2;
  logic [1:0]  ovf0, ovf1, ovf2;

  multi_operand_entry u0 (
    .freq625m(freq625m), .rst(rst), .btnC(btn[0][4]), .btnU(btn[0][3]), .btnD(btn[0][2]),
    .btnL(btn[0][1]), .btnR(btn[0][0]), .nums(nums0), .done(done0), .busy(busy0),
    .op_idx(op0), .cursor(cur0), .digits_bcd(bcd0), .neg(neg0), .ovf(ovf0));

  multi_operand_entry #(.ALLOW_NEG(1)) u1 (
    .freq625m(freq625m), .rst(rst), .btnC(btn[1][4]), .btnU(btn[1][3]), .btnD(btn[1][2]),
    .btnL(btn[1][1]), .btnR(btn[1][0]), .nums(nums1), .done(done1), .busy(busy1),
    .op_idx(op1), .cursor(cur1), .digits_bcd(bcd1), .neg(neg1), .ovf(ovf1));

  multi_operand_entry #(.DIGITS(6)) u2 (
    .freq625m(freq625m), .rst(rst), .btnC(btn[2][4]), .btnU(btn[2][3]), .btnD(btn[2][2]),
    .btnL(btn[2][1]), .btnR(btn[2][0]), .nums(nums2), .done(done2), .busy(busy2),
    .op_idx(op2), .cursor(cur2), .digits_bcd(bcd2), .neg(neg2), .ovf(ovf2));

  logic [35:0] g_nums [3];
  logic [23:0] g_bcd  [3];
  logic [2:0]  g_cur  [3];
  logic [1:0]  g_ovf  [3];
  logic        g_done [3];
  logic        g_busy [3];
  logic        g_neg  [3];
  logic        g_op   [3];
  assign g_nums[0] = nums0; assign g_nums[1] = nums1; assign g_nums[2] = nums2;
  assign g_bcd[0] = {4'd0, bcd0}; assign g_bcd[1] = {4'd0, bcd1}; assign g_bcd[2] = bcd2;
  assign g_cur[0] = cur0; assign g_cur[1] = cur1; assign g_cur[2] = cur2;
  assign g_ovf[0] = ovf0; assign g_ovf[1] = ovf1; assign g_ovf[2] = ovf2;
  assign g_done[0] = done0; assign g_done[1] = done1; assign g_done[2] = done2;
  assign g_busy[0] = busy0; assign g_busy[1] = busy1; assign g_busy[2] = busy2;
  assign g_neg[0] = neg0; assign g_neg[1] = neg1; assign g_neg[2] = neg2;
  assign g_op[0] = op0[0]; assign g_op[1] = op1[0]; assign g_op[2] = op2[0];

  // Reference model: decimal digits, cursor, sign and the operand slots
  int          m_dig  [3][9];
  int          m_cur  [3];
  bit          m_neg  [3];
  int          m_op   [3];
  logic [17:0] m_nums [3][2];
  bit          m_ovf  [3][2];
  bit          m_done [3];

  function automatic int pdig(int i);
    return (i == 2) ? 6 : 5;
  endfunction

  function automatic bit pneg(int i);
    return (i == 1);
  endfunction

  function automatic void model_reset(int i);
    for (int k = 0; k < 9; k++) m_dig[i][k] = 0;
    m_cur[i] = 0; m_neg[i] = 0; m_op[i] = 0; m_done[i] = 0;
    for (int k = 0; k < 2; k++) begin m_nums[i][k] = '0; m_ovf[i][k] = 0; end
  endfunction

  function automatic void model_act(int i, logic [4:0] m);
    longint v, lim;
    int d = pdig(i);
    int maxc = pneg(i) ? d : d - 1;
    if (m_done[i]) begin
      if (m[4]) begin
        m_done[i] = 0; m_op[i] = 0;
        for (int k = 0; k < 2; k++) begin m_nums[i][k] = '0; m_ovf[i][k] = 0; end
      end
      return;
    end
    if (m[4]) begin
      v = 0;
      for (int k = d - 1; k >= 0; k--) v = v * 10 + m_dig[i][k];
      lim = pneg(i) ? 64'd131071 : 64'd262143;
      m_ovf[i][m_op[i]] = (v > lim);
      if (v > lim) v = lim;
      if (m_neg[i]) v = (262144 - v) % 262144;
      m_nums[i][m_op[i]] = 18'(v);
      for (int k = 0; k < 9; k++) m_dig[i][k] = 0;
      m_cur[i] = 0; m_neg[i] = 0;
      if (m_op[i] == 1) m_done[i] = 1;
      else m_op[i] = m_op[i] + 1;
    end else if (m[3] || m[2]) begin
      if (pneg(i) && m_cur[i] == d) m_neg[i] = !m_neg[i];
      else if (m[3]) m_dig[i][m_cur[i]] = (m_dig[i][m_cur[i]] + 1) % 10;
      else m_dig[i][m_cur[i]] = (m_dig[i][m_cur[i]] + 9) % 10;
    end else if (m[1]) begin
      if (m_cur[i] < maxc) m_cur[i] = m_cur[i] + 1;
    end else if (m[0]) begin
      if (m_cur[i] > 0) m_cur[i] = m_cur[i] - 1;
    end
  endfunction

  function automatic logic [23:0] exp_bcd(int i);
    logic [23:0] e = '0;
    for (int k = 0; k < pdig(i); k++) e[4*k +: 4] = 4'(m_dig[i][k]);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge freq625m);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) btn[i] = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) model_reset(i);
  endtask

  task automatic press(input int i, input logic [4:0] m);
    btn[i] = m;
    tick(1);
    btn[i] = '0;
    tick(1);
  endtask

  task automatic enter_number(input int i, input int val);
    int v = val;
    for (int k = 0; k < pdig(i); k++) begin
      repeat (v % 10) press(i, 5'b01000);
      v = v / 10;
      if (k < pdig(i) - 1) press(i, 5'b00010);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) btn[i] = '0;
    btn[0][3] = 1'b1;
    tick(2);
    btn[0][3] = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    checks++;
    if ({nums0, done0, busy0, op0, cur0, bcd0, neg0, ovf0} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_u0 got nums=%h done=%b busy=%b op=%0d cur=%0d bcd=%h neg=%b ovf=%b exp all zero",
               nums0, done0, busy0, op0, cur0, bcd0, neg0, ovf0);
    end
    checks++;
    if ({nums2, done2, busy2, op2, cur2, bcd2, neg2, ovf2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_u2 got nums=%h bcd=%h exp all zero", nums2, bcd2);
    end
    press(0, 5'b01000);
    checks++;
    if (bcd0 !== 20'h00001) begin
      failures++;
      $display("FAIL reset_fresh_u got bcd=%h exp 00001", bcd0);
    end
  endtask

  task automatic test_defaults();
    int busy_cnt, done_at;
    apply_reset();
    enter_number(0, 12345);
    checks++;
    if (bcd0 !== 20'h12345 || cur0 !== 3'd4) begin
      failures++;
      $display("FAIL entry_12345 got bcd=%h cur=%0d exp 12345 cur=4", bcd0, cur0);
    end
    press(0, 5'b10000);
    tick(5);
    checks++;
    if (nums0[17:0] !== 18'd12345 || op0 !== 1'b1 || done0 !== 1'b0 || bcd0 !== '0 || cur0 !== '0) begin
      failures++;
      $display("FAIL first_operand got nums0=%0d op=%0d done=%b bcd=%h cur=%0d exp 12345 op=1 done=0",
               nums0[17:0], op0, done0, bcd0, cur0);
    end
    enter_number(0, 7);
    busy_cnt = 0;
    done_at = 0;
    btn[0][4] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      btn[0][4] = 1'b0;
      if (busy0) busy_cnt++;
      if (done0 && done_at == 0) done_at = k;
    end
    checks++;
    if (busy_cnt != 5) begin
      failures++;
      $display("FAIL busy_len got %0d exp 5", busy_cnt);
    end
    checks++;
    if (done_at != 6) begin
      failures++;
      $display("FAIL done_latency got %0d exp 6", done_at);
    end
    checks++;
    if (nums0 !== {18'd7, 18'd12345} || ovf0 !== 2'b00) begin
      failures++;
      $display("FAIL both_operands got hi=%0d lo=%0d ovf=%b exp 7 12345 00", nums0[35:18], nums0[17:0], ovf0);
    end
  endtask

  task automatic test_done_hold();
    press(0, 5'b01000);
    press(0, 5'b00010);
    press(0, 5'b00100);
    press(0, 5'b00001);
    checks++;
    if (done0 !== 1'b1 || nums0 !== {18'd7, 18'd12345} || cur0 !== '0 || bcd0 !== '0) begin
      failures++;
      $display("FAIL done_hold got done=%b nums=%h cur=%0d bcd=%h exp held", done0, nums0, cur0, bcd0);
    end
    btn[0][4] = 1'b1;
    tick(1);
    btn[0][4] = 1'b0;
    checks++;
    if (done0 !== 1'b0 || nums0 !== '0 || op0 !== '0 || ovf0 !== '0) begin
      failures++;
      $display("FAIL done_restart got done=%b nums=%h op=%0d ovf=%b exp all zero", done0, nums0, op0, ovf0);
    end
    tick(1);
  endtask

  task automatic test_cursor();
    apply_reset();
    press(0, 5'b00100);
    checks++;
    if (bcd0[3:0] !== 4'd9) begin
      failures++;
      $display("FAIL d_wrap got %0d exp 9", bcd0[3:0]);
    end
    press(0, 5'b00001);
    checks++;
    if (cur0 !== 3'd0) begin
      failures++;
      $display("FAIL r_sat got %0d exp 0", cur0);
    end
    repeat (4) press(0, 5'b00010);
    checks++;
    if (cur0 !== 3'd4) begin
      failures++;
      $display("FAIL l_four got %0d exp 4", cur0);
    end
    press(0, 5'b00010);
    checks++;
    if (cur0 !== 3'd4) begin
      failures++;
      $display("FAIL l_sat got %0d exp 4", cur0);
    end
    repeat (6) press(1, 5'b00010);
    checks++;
    if (cur1 !== 3'd5) begin
      failures++;
      $display("FAIL l_sat_sign got %0d exp 5", cur1);
    end
  endtask

  task automatic test_negative();
    apply_reset();
    repeat (5) press(1, 5'b01000);
    repeat (5) press(1, 5'b00010);
    press(1, 5'b01000);
    checks++;
    if (neg1 !== 1'b1 || bcd1 !== 20'h00005) begin
      failures++;
      $display("FAIL sign_toggle got neg=%b bcd=%h exp 1 00005", neg1, bcd1);
    end
    press(1, 5'b10000);
    tick(5);
    checks++;
    if (nums1[17:0] !== 18'h3FFFB || neg1 !== 1'b0 || ovf1[0] !== 1'b0) begin
      failures++;
      $display("FAIL neg_five got %h neg=%b ovf=%b exp 3fffb 0 0", nums1[17:0], neg1, ovf1[0]);
    end
    repeat (5) press(1, 5'b00010);
    press(1, 5'b00100);
    press(1, 5'b10000);
    tick(5);
    checks++;
    if (nums1[35:18] !== '0 || ovf1[1] !== 1'b0 || done1 !== 1'b1) begin
      failures++;
      $display("FAIL neg_zero got %h ovf=%b done=%b exp 0 0 1", nums1[35:18], ovf1[1], done1);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      press(2, 5'b00100);
      if (k < 5) press(2, 5'b00010);
    end
    checks++;
    if (bcd2 !== 24'h999999) begin
      failures++;
      $display("FAIL entry_999999 got %h exp 999999", bcd2);
    end
    press(2, 5'b10000);
    tick(6);
    checks++;
    if (nums2[17:0] !== 18'd262143 || ovf2[0] !== 1'b1) begin
      failures++;
      $display("FAIL saturate got %0d ovf=%b exp 262143 1", nums2[17:0], ovf2[0]);
    end
    press(2, 5'b01010);
    checks++;
    if (bcd2[3:0] !== 4'd1 || cur2 !== 3'd0) begin
      failures++;
      $display("FAIL priority_ul got digit=%0d cur=%0d exp 1 0", bcd2[3:0], cur2);
    end
  endtask

  task automatic test_reset_conv();
    apply_reset();
    repeat (3) press(0, 5'b01000);
    btn[0][4] = 1'b1;
    tick(1);
    btn[0][4] = 1'b0;
    tick(1);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid got %b exp 1", busy0);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({nums0, done0, busy0, op0, cur0, bcd0, neg0, ovf0} !== '0) begin
      failures++;
      $display("FAIL reset_conv got nums=%h busy=%b op=%0d bcd=%h exp all zero", nums0, busy0, op0, bcd0);
    end
    rst = 1'b0;
    tick(8);
    checks++;
    if (nums0 !== '0 || op0 !== '0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL no_writeback got nums=%h op=%0d busy=%b exp 0 0 0", nums0, op0, busy0);
    end
  endtask

  task automatic test_held();
    apply_reset();
    btn[0][3] = 1'b1;
    tick(5);
    btn[0][3] = 1'b0;
    tick(1);
    checks++;
    if (bcd0[3:0] !== 4'd1) begin
      failures++;
      $display("FAIL held_single got %0d exp 1", bcd0[3:0]);
    end
    btn[0][4] = 1'b1;
    tick(1);
    btn[0][4] = 1'b0;
    btn[0][3] = 1'b1;
    tick(9);
    btn[0][3] = 1'b0;
    tick(1);
    checks++;
    if (nums0[17:0] !== 18'd1 || bcd0 !== '0) begin
      failures++;
      $display("FAIL conv_ignore got nums=%0d bcd=%h exp 1 00000", nums0[17:0], bcd0);
    end
  endtask

  task automatic test_random(input int i, input int n);
    logic [4:0] m;
    int r;
    bit conv;
    apply_reset();
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 15);
      if (r <= 4)       m = 5'b01000;
      else if (r <= 7)  m = 5'b00100;
      else if (r <= 10) m = 5'b00010;
      else if (r <= 13) m = 5'b00001;
      else if (r == 14) m = 5'b10000;
      else              m = 5'($urandom_range(1, 31));
      conv = !m_done[i] && m[4];
      press(i, m);
      model_act(i, m);
      if (conv) tick(pdig(i));
      checks++;
      if (g_nums[i] !== {m_nums[i][1], m_nums[i][0]}) begin
        failures++;
        $display("FAIL rnd_nums inst=%0d step=%0d got %h exp %h", i, t, g_nums[i], {m_nums[i][1], m_nums[i][0]});
      end
      checks++;
      if (g_bcd[i] !== exp_bcd(i) || g_cur[i] !== 3'(m_cur[i]) || g_neg[i] !== m_neg[i]) begin
        failures++;
        $display("FAIL rnd_entry inst=%0d step=%0d got bcd=%h cur=%0d neg=%b exp bcd=%h cur=%0d neg=%b",
                 i, t, g_bcd[i], g_cur[i], g_neg[i], exp_bcd(i), m_cur[i], m_neg[i]);
      end
      checks++;
      if (g_op[i] !== 1'(m_op[i]) || g_done[i] !== m_done[i] || g_busy[i] !== 1'b0 ||
          g_ovf[i] !== {m_ovf[i][1], m_ovf[i][0]}) begin
        failures++;
        $display("FAIL rnd_status inst=%0d step=%0d got op=%0d done=%b busy=%b ovf=%b exp op=%0d done=%b busy=0 ovf=%b%b",
                 i, t, g_op[i], g_done[i], g_busy[i], g_ovf[i], m_op[i], m_done[i], m_ovf[i][1], m_ovf[i][0]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) btn[i] = '0;
    test_reset();
    test_defaults();
    test_done_hold();
    test_cursor();
    test_negative();
    test_overflow();
    test_reset_conv();
    test_held();
    test_random(0, 150);
    test_random(1, 150);
    test_random(2, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
